// File: rtl/pipe_pkg.sv
// Shared pipeline types for the elastic stage registers.
//   fd_payload_t : fetch->decode payload fields (packed, MSB first = pc)
//   FD_W         : payload width used when instantiating the IF/ID stage
//   occ_e        : occupancy of a two-entry skid stage
// fd_pack/fd_unpack convert between the struct and the flat payload bus
// that pipe_skid_reg carries, so stage boundaries stay type-safe.
package pipe_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [7:0]  pht_idx;
    logic        btb_hit;
    logic [31:0] btb_target;
  } fd_payload_t;

  localparam int FD_W = $bits(fd_payload_t);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic logic [FD_W-1:0] fd_pack(input fd_payload_t p);
    return p;
  endfunction

  function automatic fd_payload_t fd_unpack(input logic [FD_W-1:0] d);
    return fd_payload_t'(d);
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage.
// Both sides of the stage travel in one bundle:
//   in_valid/in_ready/in_data    : upstream -> stage
//   out_valid/out_ready/out_data : stage -> downstream
// modport slave  : the stage register itself
// modport master : the environment (upstream producer + downstream consumer)
interface pipe_skid_reg_if #(
  parameter int DATA_W = pipe_pkg::FD_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   i_inc    : add one this cycle unless already at all-ones
//   i_clr    : synchronous clear, wins over i_inc
//   o_cnt    : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// The main entry drives the downstream side; the skid entry catches the
// one payload that arrives while the main entry is stalled. in_ready is
// the inverted skid-valid flop, so backpressure never ripples
// combinationally from out_ready to in_ready.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   flush    : synchronous kill of both entries (same-cycle push dropped)
//   bus      : pipe_skid_reg_if.slave handshake bundle (in_* / out_*)
//   bp_cnt   : saturating count of cycles with out_valid & ~out_ready
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 106,
  parameter bit ZERO_BUB = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_skid_reg_if.slave   bus,
  output logic [CNT_W-1:0] bp_cnt
);

  occ_e              r_occ;
  logic              r_m_v;
  logic              r_s_v;
  logic [DATA_W-1:0] r_m_d;
  logic [DATA_W-1:0] r_s_d;

  logic w_push;
  logic w_pop;
  logic w_bp_inc;

  assign w_push   = bus.in_valid & ~r_s_v;
  assign w_pop    = r_m_v & bus.out_ready;
  assign w_bp_inc = r_m_v & ~bus.out_ready;

  // Occupancy FSM; valid flags are kept as their own flops so the
  // handshake outputs come straight from registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= OCC_EMPTY;
      r_m_v <= 1'b0;
      r_s_v <= 1'b0;
      r_m_d <= '0;
      r_s_d <= '0;
    end else if (flush) begin
      // Zero the data too so a killed payload can never leak out,
      // even with ZERO_BUB=0.
      r_occ <= OCC_EMPTY;
      r_m_v <= 1'b0;
      r_s_v <= 1'b0;
      r_m_d <= '0;
      r_s_d <= '0;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_push) begin
            r_occ <= OCC_ONE;
            r_m_v <= 1'b1;
            r_m_d <= bus.in_data;
          end
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            r_m_d <= bus.in_data;
          end else if (w_push) begin
            r_occ <= OCC_FULL;
            r_s_v <= 1'b1;
            r_s_d <= bus.in_data;
          end else if (w_pop) begin
            r_occ <= OCC_EMPTY;
            r_m_v <= 1'b0;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (w_pop) begin
            r_occ <= OCC_ONE;
            r_s_v <= 1'b0;
            r_m_d <= r_s_d;
          end
        end
        default: begin
          r_occ <= OCC_EMPTY;
          r_m_v <= 1'b0;
          r_s_v <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = r_m_v;
  assign bus.in_ready  = ~r_s_v;
  assign bus.out_data  = (ZERO_BUB && !r_m_v) ? '0 : r_m_d;

  sat_counter #(
    .W(CNT_W)
  ) u_bp_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_bp_inc),
    .i_clr (1'b0),
    .o_cnt (bp_cnt)
  );

endmodule
